// File: rtl/dma.sv
// dma: memory-to-memory block copy engine, a second bus initiator beside the cpu.
//
// Copies CNT words from word address SRC to word address DST. Each word is one read
// access and then one write access on the master port. A level irq is raised on
// completion when enabled.
//
// Optional feature macro: DMA_FILL_EN
//   defined   - CTRL b4 at start selects fill mode. SRC holds a 32-bit pattern that is
//               written to CNT consecutive DST words, with no read accesses.
//   undefined - copy mode only. CTRL b4 is ignored on write and reads back as 0.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   stb, we, addr       slave access: strobe, write enable, register select
//   data_in, data_out   slave write / read data (data_out is 0 when stb=0)
//   ack                 slave acknowledge (= stb, zero wait)
//   irq                 completion interrupt, level (done & ien)
//   m_stb, m_we         master strobe / write enable (registered)
//   m_addr, m_dout      master word address / write data (registered)
//   m_din, m_ack        master read data / acknowledge from the responder
//
// Register map (addr)
//   0 SRC   1 DST   2 CNT (live count)
//   3 CTRL  write: b0 start, b1 ien, b2 clear done, b3 abort, b4 fill
//           read : b0 busy,  b1 ien, b2 done,       b3 aborted, b4 fill
module dma #(
    parameter int ADDR_W = 22,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stb,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              ack,
    output logic              irq,
    output logic              m_stb,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_dout,
    input  logic [31:0]       m_din,
    input  logic              m_ack
);

`ifdef DMA_FILL_EN
    // SRC doubles as the 32-bit fill pattern, so it is kept at full width.
    localparam int SRC_W = 32;
`else
    localparam int SRC_W = ADDR_W;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [SRC_W-1:0]  src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ien_q;
    logic              done_q;
    logic              aborted_q;
    logic              fill_q;
    logic              abort_pend_q;

    logic              busy;
    logic              reg_wr;
    logic              ctrl_wr;
    logic              start_req;
    logic              fill_req;
    logic [ADDR_W-1:0] src_inc;
    logic [ADDR_W-1:0] dst_inc;
    logic [CNT_W-1:0]  cnt_dec;

    assign busy      = (state_q != IDLE);
    assign reg_wr    = stb & we;
    assign ctrl_wr   = reg_wr && (addr == 2'd3);
    assign start_req = ctrl_wr && data_in[0] && !busy;

    // Address arithmetic is done at ADDR_W bits so it wraps without any extra logic.
    assign src_inc   = src_q[ADDR_W-1:0] + 1'b1;
    assign dst_inc   = dst_q + 1'b1;
    assign cnt_dec   = cnt_q - 1'b1;

`ifdef DMA_FILL_EN
    assign fill_req  = data_in[4];
`else
    assign fill_req  = 1'b0;
    logic unused_data_hi;
    assign unused_data_hi = ^data_in[31:ADDR_W];
`endif

    assign ack = stb;
    assign irq = done_q & ien_q;

    always_comb begin
        data_out = 32'd0;
        if (stb) begin
            case (addr)
                2'd0:    data_out = 32'(src_q);
                2'd1:    data_out = 32'(dst_q);
                2'd2:    data_out = 32'(cnt_q);
                default: data_out = {27'd0, fill_q, aborted_q, done_q, ien_q, busy};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            cnt_q        <= '0;
            ien_q        <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            fill_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            m_stb        <= 1'b0;
            m_we         <= 1'b0;
            m_addr       <= '0;
            m_dout       <= '0;
        end else begin
            // Transfer parameters are frozen while a transfer is in flight.
            if (reg_wr && !busy) begin
                case (addr)
                    2'd0:    src_q <= data_in[SRC_W-1:0];
                    2'd1:    dst_q <= data_in[ADDR_W-1:0];
                    2'd2:    cnt_q <= data_in[CNT_W-1:0];
                    default: ;
                endcase
            end

            // Control bits first; the state machine below overrides done/aborted
            // where a start or completion lands in the same cycle.
            if (ctrl_wr) begin
                ien_q <= data_in[1];
                if (data_in[2])
                    done_q <= 1'b0;
                if (data_in[3] && (state_q == RD || state_q == WR))
                    abort_pend_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start_req) begin
                        done_q       <= 1'b0;
                        aborted_q    <= 1'b0;
                        abort_pend_q <= 1'b0;
                        fill_q       <= fill_req;
                        if (cnt_q == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (fill_req) begin
                            state_q <= WR;
                            m_stb   <= 1'b1;
                            m_we    <= 1'b1;
                            m_addr  <= dst_q;
                            m_dout  <= 32'(src_q);
                        end else begin
                            state_q <= RD;
                            m_stb   <= 1'b1;
                            m_we    <= 1'b0;
                            m_addr  <= src_q[ADDR_W-1:0];
                        end
                    end
                end

                RD: begin
                    // m_dout is the word buffer: it holds the read data for the write.
                    if (m_ack) begin
                        state_q <= WR;
                        m_we    <= 1'b1;
                        m_addr  <= dst_q;
                        m_dout  <= m_din;
                    end
                end

                WR: begin
                    if (m_ack) begin
                        dst_q <= dst_inc;
                        cnt_q <= cnt_dec;
                        if (!fill_q)
                            src_q[ADDR_W-1:0] <= src_inc;
                        if ((cnt_dec == '0) || abort_pend_q) begin
                            state_q      <= DONE;
                            m_stb        <= 1'b0;
                            m_we         <= 1'b0;
                            done_q       <= 1'b1;
                            aborted_q    <= abort_pend_q;
                            abort_pend_q <= 1'b0;
                        end else if (fill_q) begin
                            // Fill keeps writing; the pattern in m_dout is unchanged.
                            m_addr <= dst_inc;
                        end else begin
                            state_q <= RD;
                            m_we    <= 1'b0;
                            m_addr  <= src_inc;
                        end
                    end
                end

                default: begin
                    // DONE: re-assert done so a clear landing on this edge loses.
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma.sv
module tb_dma;
    localparam int AW = 22;
    localparam logic [31:0] AMASK = 32'h003F_FFFF;
`ifdef DMA_FILL_EN
    localparam bit          FILL_OK = 1'b1;
    localparam logic [31:0] SRC_RB  = 32'hFFFF_FFFF;
`else
    localparam bit          FILL_OK = 1'b0;
    localparam logic [31:0] SRC_RB  = 32'h003F_FFFF;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stb, we;
    logic [1:0]    addr;
    logic [31:0]   data_in, data_out;
    logic          ack, irq;
    logic          m_stb, m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_dout, m_din;
    logic          m_ack;

    always #5 clk = ~clk;

    dma u_dma (
        .clk(clk), .rst_n(rst_n), .stb(stb), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .ack(ack), .irq(irq),
        .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_dout(m_dout),
        .m_din(m_din), .m_ack(m_ack)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    // ---------------- memory responder and access log ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [31:0]   d;
        int            len;
    } acc_t;

    acc_t        acc_log[$];
    logic [31:0] mem[int unsigned];
    int          wcnt = 0;
    int          wait_n = 0;
    int          stb_cycles = 0;
    int          viol = 0;
    logic          held = 1'b0;
    logic [AW-1:0] h_addr;
    logic          h_we;
    logic [31:0]   h_dout;

    function automatic logic [31:0] init_val(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    assign m_ack = m_stb && (wcnt == wait_n);

    always @(negedge clk)
        m_din <= mem.exists(32'(m_addr)) ? mem[32'(m_addr)] : init_val(m_addr);

    always @(posedge clk) begin
        if (!rst_n) begin
            held <= 1'b0;
            wcnt <= 0;
        end else if (m_stb) begin
            acc_t e;
            stb_cycles <= stb_cycles + 1;
            if (held && (m_addr !== h_addr || m_we !== h_we || (m_we && m_dout !== h_dout)))
                viol <= viol + 1;
            if (m_ack) begin
                e.we  = m_we;
                e.a   = m_addr;
                e.d   = m_we ? m_dout : m_din;
                e.len = wcnt + 1;
                acc_log.push_back(e);
                if (m_we) mem[32'(m_addr)] = m_dout;
                wcnt <= 0;
                held <= 1'b0;
            end else begin
                wcnt   <= wcnt + 1;
                held   <= 1'b1;
                h_addr <= m_addr;
                h_we   <= m_we;
                h_dout <= m_dout;
            end
        end else begin
            if (held) viol <= viol + 1;
            held <= 1'b0;
            wcnt <= 0;
        end
    end

    // ---------------- slave access (called at a negedge) ----------------
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        stb = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] r);
        stb = 1'b1; we = 1'b0; addr = a;
        #1 r = data_out;
        @(negedge clk);
        stb = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] r;
        int k;
        for (k = 0; k < 3000; k++) begin
            bus_rd(2'd3, r);
            if (r[0] == 1'b0) break;
        end
        chk({tag, "_finished"}, 32'(k < 3000), 32'd1);
    endtask

    // Reference: word i reads SRC+i and writes DST+i, addresses modulo 2**22.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] c,
                            input int wn, input logic [31:0] go, input string tag);
        acc_t        exp_q[$];
        acc_t        e;
        logic [31:0] refm[int unsigned];
        logic [31:0] v, sa, da, r;
        int          base, sbase, vbase, n, errs, cyc;
        logic        fill;
        wait_n = wn;
        bus_wr(2'd0, s);
        bus_wr(2'd1, d);
        bus_wr(2'd2, c);
        bus_wr(2'd3, 32'h8);          // abort while idle must do nothing
        refm = mem;
        fill = FILL_OK && go[4];
        cyc  = 0;
        for (int i = 0; i < int'(c); i++) begin
            sa = (s + 32'(i)) & AMASK;
            da = (d + 32'(i)) & AMASK;
            if (fill) begin
                v = s;
            end else begin
                v = refm.exists(sa) ? refm[sa] : init_val(sa[AW-1:0]);
                e.we = 1'b0; e.a = sa[AW-1:0]; e.d = v; e.len = wn + 1;
                exp_q.push_back(e);
                cyc += wn + 1;
            end
            e.we = 1'b1; e.a = da[AW-1:0]; e.d = v; e.len = wn + 1;
            exp_q.push_back(e);
            cyc += wn + 1;
            refm[da] = v;
        end
        base  = acc_log.size();
        sbase = stb_cycles;
        vbase = viol;
        bus_wr(2'd3, go);
        wait_done(tag);
        n = acc_log.size() - base;
        chk({tag, "_accesses"}, n, exp_q.size());
        errs = 0;
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            e = acc_log[base + i];
            if (e.we !== exp_q[i].we || e.a !== exp_q[i].a || e.d !== exp_q[i].d ||
                e.len != exp_q[i].len)
                errs++;
        end
        chk({tag, "_seq_errs"}, errs, 0);
        errs = 0;
        foreach (exp_q[i])
            if (exp_q[i].we && (!mem.exists(32'(exp_q[i].a)) ||
                                mem[32'(exp_q[i].a)] !== refm[32'(exp_q[i].a)]))
                errs++;
        chk({tag, "_mem_errs"}, errs, 0);
        chk({tag, "_stb_cycles"}, stb_cycles - sbase, cyc);
        chk({tag, "_stability"}, viol - vbase, 0);
        bus_rd(2'd2, r);
        chk({tag, "_cnt"}, r, 32'd0);
        bus_rd(2'd3, r);
        chk({tag, "_ctrl"}, r, 32'h4 | (go & 32'h2) | (fill ? 32'h10 : 32'h0));
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0] r;
        int base, sb, k;

        vecs[0]  = '{we:1'b0, a:2'd0, d:32'h0,         exp:32'h0,         nm:"rst_src"};
        vecs[1]  = '{we:1'b0, a:2'd1, d:32'h0,         exp:32'h0,         nm:"rst_dst"};
        vecs[2]  = '{we:1'b0, a:2'd2, d:32'h0,         exp:32'h0,         nm:"rst_cnt"};
        vecs[3]  = '{we:1'b0, a:2'd3, d:32'h0,         exp:32'h0,         nm:"rst_ctrl"};
        vecs[4]  = '{we:1'b1, a:2'd0, d:32'hFFFF_FFFF, exp:32'h0,         nm:"w_src"};
        vecs[5]  = '{we:1'b0, a:2'd0, d:32'h0,         exp:SRC_RB,        nm:"rb_src"};
        vecs[6]  = '{we:1'b1, a:2'd1, d:32'hFFC0_0123, exp:32'h0,         nm:"w_dst"};
        vecs[7]  = '{we:1'b0, a:2'd1, d:32'h0,         exp:32'h0000_0123, nm:"rb_dst"};
        vecs[8]  = '{we:1'b1, a:2'd2, d:32'hABCD_1234, exp:32'h0,         nm:"w_cnt"};
        vecs[9]  = '{we:1'b0, a:2'd2, d:32'h0,         exp:32'h0000_1234, nm:"rb_cnt"};
        vecs[10] = '{we:1'b1, a:2'd3, d:32'h12,        exp:32'h0,         nm:"w_ien"};
        vecs[11] = '{we:1'b0, a:2'd3, d:32'h0,         exp:32'h2,         nm:"rb_ien"};
        vecs[12] = '{we:1'b1, a:2'd3, d:32'h18,        exp:32'h0,         nm:"w_idle_abort"};
        vecs[13] = '{we:1'b0, a:2'd3, d:32'h0,         exp:32'h0,         nm:"rb_idle_abort"};

        rst_n = 1'b0; stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'd0;
        #1;
        chk("rst_m_stb", 32'(m_stb), 32'd0);
        chk("rst_m_we", 32'(m_we), 32'd0);
        chk("rst_m_addr", 32'(m_addr), 32'd0);
        chk("rst_m_dout", m_dout, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // register file
        foreach (vecs[i]) begin
            if (vecs[i].we) begin
                bus_wr(vecs[i].a, vecs[i].d);
            end else begin
                bus_rd(vecs[i].a, r);
                chk(vecs[i].nm, r, vecs[i].exp);
            end
        end
        #1;
        chk("idle_data_out", data_out, 32'd0);
        chk("idle_ack", 32'(ack), 32'd0);
        stb = 1'b1; addr = 2'd2; #1;
        chk("strobe_ack", 32'(ack), 32'd1);
        stb = 1'b0;
        @(negedge clk);

        // basic copy, zero-wait then 3 wait cycles per access
        run_copy(32'h100, 32'h200, 32'd4, 0, 32'h1, "basic");
        run_copy(32'h100, 32'h200, 32'd4, 3, 32'h1, "wait3");

        // zero-length start with irq; clear on the DONE->IDLE edge loses
        wait_n = 0;
        sb = stb_cycles;
        bus_wr(2'd2, 32'd0);
        bus_wr(2'd3, 32'h3);
        #1 chk("zero_irq_set", 32'(irq), 32'd1);
        bus_wr(2'd3, 32'h6);
        #1 chk("clr_vs_set_edge", 32'(irq), 32'd1);
        bus_wr(2'd3, 32'h6);
        #1 chk("irq_cleared", 32'(irq), 32'd0);
        chk("zero_no_stb", stb_cycles - sb, 32'd0);
        @(negedge clk);

        // start beats clear in one write; parameter writes ignored while busy
        bus_wr(2'd3, 32'h1);
        @(negedge clk);
        bus_rd(2'd3, r);
        chk("done_before_restart", r, 32'h4);
        wait_n = 3;
        bus_wr(2'd0, 32'h500);
        bus_wr(2'd1, 32'h600);
        bus_wr(2'd2, 32'd1);
        bus_wr(2'd3, 32'h5);
        bus_rd(2'd3, r);
        chk("start_wins_clear", r, 32'h1);
        bus_wr(2'd0, 32'h777);
        bus_rd(2'd0, r);
        chk("src_locked_busy", r, 32'h500);
        wait_done("restart");
        bus_rd(2'd0, r);
        chk("src_after_one", r, 32'h501);

        // abort lands on the word boundary after word 10
        wait_n = 2;
        bus_wr(2'd0, 32'h1000);
        bus_wr(2'd1, 32'h2000);
        bus_wr(2'd2, 32'd100);
        base = acc_log.size();
        bus_wr(2'd3, 32'h1);
        for (k = 0; k < 2000; k++) begin
            if (acc_log.size() - base >= 21) break;
            @(negedge clk);
        end
        chk("abort_reached_word10", 32'(k < 2000), 32'd1);
        bus_wr(2'd3, 32'h8);
        wait_done("abort");
        bus_rd(2'd2, r);
        chk("abort_cnt", r, 32'd89);
        bus_rd(2'd3, r);
        chk("abort_ctrl", r, 32'hC);
        sb = stb_cycles;
        repeat (10) @(negedge clk);
        chk("abort_accesses", acc_log.size() - base, 32'd22);
        chk("abort_quiet", stb_cycles - sb, 32'd0);

        // address wrap
        run_copy(32'h003F_FFFF, 32'h003F_FFFE, 32'd2, 0, 32'h1, "wrap");

`ifdef DMA_FILL_EN
        run_copy(32'hDEAD_BEEF, 32'h40, 32'd3, 0, 32'h11, "fill");
`endif

        // randomized copies
        for (int it = 0; it < 6; it++)
            run_copy($urandom & AMASK, $urandom & AMASK, 32'($urandom_range(1, 12)),
                     int'($urandom_range(0, 3)), 32'h1 | ($urandom & 32'h2), "rand");

        // reset in the middle of a transfer
        wait_n = 3;
        bus_wr(2'd0, 32'h10);
        bus_wr(2'd1, 32'h20);
        bus_wr(2'd2, 32'd5);
        bus_wr(2'd3, 32'h3);
        repeat (3) @(negedge clk);
        chk("stb_before_rst", 32'(m_stb), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_drops_stb", 32'(m_stb), 32'd0);
        chk("rst_clears_addr", 32'(m_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb = stb_cycles;
        bus_rd(2'd2, r);
        chk("rst_cnt_cleared", r, 32'd0);
        bus_rd(2'd3, r);
        chk("rst_ctrl_cleared", r, 32'd0);
        repeat (5) @(negedge clk);
        chk("rst_transfer_lost", stb_cycles - sb, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
